// File: rtl/fcb_apb_pkg.sv
// Shared definitions for the FCB APB front-end: FSM encoding, command bits and
// write-FIFO entry layout.
package fcb_apb_pkg;

  typedef logic [2:0] state_t;

  localparam state_t StIdle   = 3'd0;
  localparam state_t StWr     = 3'd1;
  localparam state_t StRdCmd  = 3'd2;
  localparam state_t StRdWait = 3'd3;
  localparam state_t StRdPop  = 3'd4;
  localparam state_t StDone   = 3'd5;
  localparam state_t StErr    = 3'd6;

  localparam logic CMD_WR = 1'b1;
  localparam logic CMD_RD = 1'b0;

  localparam int unsigned ENT_CMD_BIT  = 39;
  localparam int unsigned ENT_ADDR_MSB = 38;
  localparam int unsigned ENT_ADDR_LSB = 32;
  localparam int unsigned ENT_DATA_MSB = 31;

  localparam logic [6:0] CFG_DATA_ADDR = 7'h20;

  function automatic logic [39:0] make_entry(input logic        cmd,
                                             input logic [6:0]  addr,
                                             input logic [31:0] data);
    logic [39:0] e;
    e                             = '0;
    e[ENT_CMD_BIT]                = cmd;
    e[ENT_ADDR_MSB:ENT_ADDR_LSB]  = addr;
    e[ENT_DATA_MSB:0]             = data;
    return e;
  endfunction

endpackage

// File: rtl/fcb_apb_frwf_bridge.sv
// APB3 slave that turns APB writes/reads into FCB write-FIFO entries and returns
// read-back FIFO words on PRDATA, with full back-pressure and a read timeout.
module fcb_apb_frwf_bridge
  import fcb_apb_pkg::*;
#(
  parameter int unsigned RD_TIMEOUT = 256,
  parameter int unsigned TMO_W      = 8,
  parameter logic [6:0]  POP_ADDR   = 7'h7F
) (
  input  logic        fcb_sys_clk,
  input  logic        fcb_sys_rst_n,
  input  logic        fcb_apb_en,
  input  logic        fcb_psel,
  input  logic        fcb_penable,
  input  logic        fcb_pwrite,
  input  logic [8:0]  fcb_paddr,
  input  logic [31:0] fcb_pwdata,
  output logic [31:0] fcb_prdata,
  output logic        fcb_pready,
  output logic        fcb_pslverr,
  input  logic        frwf_wff_full,
  input  logic        frwf_crf_empty,
  input  logic [31:0] frwf_crf_rd_data,
  output logic        faps_frwf_apb_on,
  output logic [39:0] faps_frwf_wff_wr_data,
  output logic        faps_frwf_wff_wr_en,
  output logic        faps_frwf_crf_rd_en
);

  localparam logic [TMO_W-1:0] TmoLast = TMO_W'(RD_TIMEOUT - 1);

  state_t            state_q, state_d;
  logic [TMO_W-1:0]  timer_q, timer_d;
  logic [31:0]       prdata_q, prdata_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [6:0]        addr_q, addr_d;
  logic              apb_on_q;

  logic              wr_en;
  logic [39:0]       wr_data;
  logic              rd_en;

  // Byte-lane bits carry no meaning for word-wide SFRs.
  logic unused_paddr_lsb;
  assign unused_paddr_lsb = ^fcb_paddr[1:0];

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    prdata_d = prdata_q;
    wdata_d  = wdata_q;
    addr_d   = addr_q;
    wr_en    = 1'b0;
    wr_data  = '0;
    rd_en    = 1'b0;

    case (state_q)
      StIdle: begin
        if (fcb_psel && !fcb_penable) begin
          addr_d  = fcb_paddr[8:2];
          wdata_d = fcb_pwdata;
          if (!apb_on_q) begin
            state_d = StErr;
          end else if (fcb_pwrite) begin
            state_d = StWr;
          end else if (fcb_paddr[8:2] == POP_ADDR) begin
            state_d = StRdWait;
            timer_d = '0;
          end else begin
            state_d = StRdCmd;
          end
        end
      end
      StWr: begin
        if (!frwf_wff_full) begin
          wr_en   = 1'b1;
          wr_data = make_entry(CMD_WR, addr_q, wdata_q);
          state_d = StDone;
        end
      end
      StRdCmd: begin
        if (!frwf_wff_full) begin
          wr_en   = 1'b1;
          wr_data = make_entry(CMD_RD, addr_q, 32'h0);
          state_d = StRdWait;
          timer_d = '0;
        end
      end
      StRdWait: begin
        if (!frwf_crf_empty) begin
          state_d = StRdPop;
        end else if (timer_q == TmoLast) begin
          state_d = StErr;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      StRdPop: begin
        rd_en    = 1'b1;
        prdata_d = frwf_crf_rd_data;
        state_d  = StDone;
      end
      default: state_d = StIdle;
    endcase

    // Master abandoned the transfer: stop before any further FIFO side effect.
    if (state_q != StIdle && !fcb_psel) begin
      state_d  = StIdle;
      wr_en    = 1'b0;
      wr_data  = '0;
      rd_en    = 1'b0;
      prdata_d = prdata_q;
    end
  end

  always_ff @(posedge fcb_sys_clk) begin
    if (!fcb_sys_rst_n) begin
      state_q  <= StIdle;
      timer_q  <= '0;
      prdata_q <= '0;
      wdata_q  <= '0;
      addr_q   <= '0;
      apb_on_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      prdata_q <= prdata_d;
      wdata_q  <= wdata_d;
      addr_q   <= addr_d;
      apb_on_q <= fcb_apb_en;
    end
  end

  // FIFO strobes are masked while reset is held so an aborted transfer leaves no trace.
  assign faps_frwf_wff_wr_en   = wr_en & fcb_sys_rst_n;
  assign faps_frwf_wff_wr_data = fcb_sys_rst_n ? wr_data : 40'h0;
  assign faps_frwf_crf_rd_en   = rd_en & fcb_sys_rst_n;
  assign faps_frwf_apb_on      = apb_on_q;

  assign fcb_pready  = (state_q == StDone) || (state_q == StErr);
  assign fcb_pslverr = (state_q == StErr);
  assign fcb_prdata  = (state_q == StErr) ? 32'h0 : prdata_q;

endmodule

// File: tb/tb_fcb_apb_frwf_bridge.sv
// Scoreboard bench for the FCB APB bridge: directed cases plus randomized traffic
// checked against a transaction-level model of SFR memory and FIFOs.
module tb_fcb_apb_frwf_bridge;
  import fcb_apb_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        apb_en = 1'b0;
  logic        psel = 1'b0;
  logic        penable = 1'b0;
  logic        pwrite = 1'b0;
  logic [8:0]  paddr = '0;
  logic [31:0] pwdata = '0;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;
  logic        wff_full = 1'b0;
  logic        crf_empty = 1'b1;
  logic [31:0] crf_rd_data = '0;
  logic        apb_on;
  logic [39:0] wr_data;
  logic        wr_en;
  logic        rd_en;

  always #5 clk = ~clk;

  fcb_apb_frwf_bridge dut (
    .fcb_sys_clk           (clk),
    .fcb_sys_rst_n         (rst_n),
    .fcb_apb_en            (apb_en),
    .fcb_psel              (psel),
    .fcb_penable           (penable),
    .fcb_pwrite            (pwrite),
    .fcb_paddr             (paddr),
    .fcb_pwdata            (pwdata),
    .fcb_prdata            (prdata),
    .fcb_pready            (pready),
    .fcb_pslverr           (pslverr),
    .frwf_wff_full         (wff_full),
    .frwf_crf_empty        (crf_empty),
    .frwf_crf_rd_data      (crf_rd_data),
    .faps_frwf_apb_on      (apb_on),
    .faps_frwf_wff_wr_data (wr_data),
    .faps_frwf_wff_wr_en   (wr_en),
    .faps_frwf_crf_rd_en   (rd_en)
  );

  typedef struct {
    bit          is_wr;
    bit          err;
    bit          chk_data;
    logic [31:0] data;
    int          npush;
    int          lat;
  } resp_t;

  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  resp_t       resp_q[$];
  logic [39:0] push_q[$];
  logic [31:0] pre_q[$];
  logic [31:0] crf_q[$];
  bit   [31:0] ref_mem [128];
  bit   [31:0] dev_mem [128];
  bit          crf_mute = 1'b0;
  int          crf_delay = 2;
  int          exp_pops = 0;
  int          mon_pops = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor and read-back FIFO model: sample at negedge, update FIFO just after posedge.
  always begin : mon
    resp_t       r;
    int          seen_push;
    int          setup_cyc;
    int          last_push_cyc;
    int          pend_cnt;
    logic [31:0] pend_word;
    bit          pop_now;
    bit          rdcmd_new;
    logic [6:0]  rdcmd_addr;
    if (cyc == 0) begin
      seen_push = 0; setup_cyc = 0; last_push_cyc = -10; pend_cnt = -1; pend_word = '0;
      rdcmd_addr = '0;
    end
    @(negedge clk);
    pop_now   = 1'b0;
    rdcmd_new = 1'b0;
    if (!rst_n) seen_push = 0;
    if (psel && !penable) setup_cyc = cyc;
    if (!wr_en) chk("wr_data_zero_when_idle", wr_data, 40'h0);
    if (wr_en) begin
      chk("push_while_full", wff_full, 1'b0);
      if (push_q.size() == 0) chk("unexpected_push", wr_data, 40'h0);
      else chk("push_entry", wr_data, push_q.pop_front());
      seen_push++;
      last_push_cyc = cyc;
      if (wr_data[39]) dev_mem[wr_data[38:32]] = wr_data[31:0];
      else begin
        rdcmd_new  = 1'b1;
        rdcmd_addr = wr_data[38:32];
      end
    end
    if (rd_en) begin
      mon_pops++;
      pop_now = 1'b1;
      chk("pop_from_nonempty", crf_q.size() > 0, 1'b1);
    end
    if (pready) begin
      if (resp_q.size() == 0) chk("unexpected_pready", pready, 1'b0);
      else begin
        r = resp_q.pop_front();
        chk("pslverr", pslverr, r.err);
        if (r.chk_data) chk("prdata", prdata, r.data);
        chk("pushes_per_xfer", seen_push, r.npush);
        if (r.lat > 0) chk("latency", cyc - setup_cyc + 1, r.lat);
        if (r.is_wr && !r.err) chk("pready_after_push", cyc - last_push_cyc, 1);
      end
      seen_push = 0;
    end
    @(posedge clk);
    #1;
    if (pop_now && crf_q.size() > 0) void'(crf_q.pop_front());
    while (pre_q.size() > 0) crf_q.push_back(pre_q.pop_front());
    if (pend_cnt == 0) begin
      crf_q.push_back(pend_word);
      pend_cnt = -1;
    end else if (pend_cnt > 0) begin
      pend_cnt--;
    end
    if (!rst_n) pend_cnt = -1;
    if (rdcmd_new && !crf_mute) begin
      pend_word = dev_mem[rdcmd_addr];
      pend_cnt  = crf_delay;
    end
    crf_empty   = (crf_q.size() == 0);
    crf_rd_data = crf_empty ? 32'h0 : crf_q[0];
  end

  // One APB transfer; the expected response comes from the SFR/FIFO model.
  task automatic xfer(input bit wr, input logic [6:0] a, input logic [31:0] d, input int lat,
                      input int full_cycles, input bit rand_full, input bit en, input bit tmo);
    resp_t r;
    int    n;
    r.is_wr = wr; r.err = 1'b0; r.chk_data = 1'b0; r.data = '0; r.npush = 0; r.lat = lat;
    if (!en) begin
      r.err = 1'b1; r.chk_data = 1'b1;
    end else if (wr) begin
      push_q.push_back({1'b1, a, d});
      ref_mem[a] = d;
      r.npush = 1;
    end else begin
      r.chk_data = 1'b1;
      if (a == 7'h7F) begin
        if (tmo) r.err = 1'b1;
        else begin
          pre_q.push_back(d);
          r.data = d;
          exp_pops++;
        end
      end else begin
        push_q.push_back({1'b0, a, 32'h0});
        r.npush = 1;
        r.data  = ref_mem[a];
        exp_pops++;
      end
    end
    resp_q.push_back(r);
    wff_full = (full_cycles > 0);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = {a, 2'b00}; pwdata = d;
    @(posedge clk); #1;
    penable = 1'b1;
    n = 0;
    while (n < 600) begin
      if (rand_full) wff_full = ($urandom_range(0, 3) == 0);
      else wff_full = (n < full_cycles);
      @(negedge clk);
      if (pready) break;
      @(posedge clk); #1;
      n++;
    end
    if (n >= 600) chk("pready_timeout", 1'b0, 1'b1);
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0; wff_full = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ctl"}, {pready, pslverr, wr_en, rd_en, apb_on}, 5'b0);
    chk({tag, "_prdata"}, prdata, 32'h0);
    chk({tag, "_wr_data"}, wr_data, 40'h0);
  endtask

  initial begin
    #400_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          k_wr;
    int          kind;
    logic [6:0]  a;
    logic [31:0] d;
    apb_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk_all_zero("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    xfer(1'b1, CFG_DATA_ADDR, 32'hA5A5_0001, 3, 0, 1'b0, 1'b1, 1'b0);
    xfer(1'b1, 7'h11, 32'h1234_5678, 8, 5, 1'b0, 1'b1, 1'b0);
    xfer(1'b1, 7'h04, 32'h0000_005A, 3, 0, 1'b0, 1'b1, 1'b0);
    crf_delay = 2;
    xfer(1'b0, 7'h04, 32'h0, 0, 0, 1'b0, 1'b1, 1'b0);
    xfer(1'b0, 7'h7F, 32'hCAFE_F00D, 4, 0, 1'b0, 1'b1, 1'b0);
    crf_mute = 1'b1;
    xfer(1'b0, 7'h7F, 32'h0, 258, 0, 1'b0, 1'b1, 1'b1);
    crf_mute = 1'b0;

    apb_en = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("apb_on_off", apb_on, 1'b0);
    @(posedge clk); #1;
    xfer(1'b1, 7'h22, 32'hDEAD_BEEF, 2, 0, 1'b0, 1'b0, 1'b0);
    apb_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Reset while waiting on the read-back FIFO.
    crf_mute = 1'b1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 9'h1FC;
    @(posedge clk); #1;
    penable = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_cycle_no_strobe", {wr_en, rd_en}, 2'b00);
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
    @(negedge clk);
    chk_all_zero("mid_rst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    crf_mute = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    xfer(1'b1, 7'h05, 32'h0BAD_CAFE, 3, 0, 1'b0, 1'b1, 1'b0);

    for (int i = 0; i < 40; i++) begin
      kind      = $urandom_range(0, 2);
      a         = 7'($urandom_range(0, 126));
      d         = $urandom;
      crf_delay = $urandom_range(0, 5);
      k_wr      = (kind == 0);
      if (kind == 2) a = 7'h7F;
      xfer(k_wr, a, d, 0, 0, 1'b1, 1'b1, 1'b0);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    repeat (5) @(posedge clk);
    #1;
    chk("resp_queue_drained", resp_q.size(), 0);
    chk("push_queue_drained", push_q.size(), 0);
    chk("total_pops", mon_pops, exp_pops);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fcb_apb_frwf_bridge.md
Name: fcb_apb_frwf_bridge

Overview:
- APB3 slave front-end that sits directly upstream of the FCB read/write FIFO stage.
- Converts APB writes into 40-bit write-FIFO entries {cmd, sfr_addr[6:0], data[31:0]}.
- Converts APB reads into SFR-read commands, then waits for the read-back FIFO and returns the popped word on PRDATA.
- Applies PREADY back-pressure on write-FIFO full, and raises PSLVERR on read timeout or when the bridge is disabled.

Parameters:
- RD_TIMEOUT, 256: cycles allowed in a read-wait state before the transfer errors out.
- TMO_W, 8: width of the timeout counter; must satisfy 2^TMO_W >= RD_TIMEOUT.
- POP_ADDR, 7'h7F: SFR address that pops the read-back FIFO directly without issuing a read command.

Ports:
- fcb_sys_clk  in  1  system clock
- fcb_sys_rst_n  in  1  reset; synchronous, active-low
- fcb_apb_en  in  1  bridge enable
- fcb_psel  in  1  APB select
- fcb_penable  in  1  APB enable
- fcb_pwrite  in  1  APB direction, 1 = write
- fcb_paddr  in  9  APB byte address; bits [8:2] give the SFR address
- fcb_pwdata  in  32  APB write data
- fcb_prdata  out  32  APB read data
- fcb_pready  out  1  APB ready
- fcb_pslverr  out  1  APB error
- frwf_wff_full  in  1  write-FIFO full
- frwf_crf_empty  in  1  read-back FIFO empty
- frwf_crf_rd_data  in  32  read-back FIFO head word
- faps_frwf_apb_on  out  1  APB path on
- faps_frwf_wff_wr_data  out  40  write-FIFO entry
- faps_frwf_wff_wr_en  out  1  write-FIFO push, single-cycle pulse
- faps_frwf_crf_rd_en  out  1  read-back FIFO pop, single-cycle pulse

Behaviour:
- Reset (sync, rst_n=0 at a clock edge):
  - State goes to IDLE; timer, prdata register and err flag clear to 0.
  - All outputs are 0, including pready and apb_on.
  - A reset in mid-transfer abandons the transfer; no push or pop is emitted on the reset cycle or after it.
- apb_on: registered copy of fcb_apb_en, so one cycle of latency.
- Entry formats:
  - Write entry: {1'b1, paddr[8:2], pwdata}.
  - Read entry: {1'b0, paddr[8:2], 32'h0}.
  - wff_wr_data is 0 whenever wff_wr_en is 0.
- States: IDLE, WR, RD_CMD, RD_WAIT, RD_POP, DONE, ERR.
- IDLE:
  - Transfers are decoded only in the setup phase (psel=1, penable=0).
  - apb_on=0 -> ERR.
  - pwrite=1 -> WR.
  - pwrite=0 and address == POP_ADDR -> RD_WAIT, timer cleared.
  - Otherwise -> RD_CMD.
  - Address and wdata are captured into registers at decode.
- WR:
  - wff_full=0 -> wr_en=1 with the write entry, then DONE.
  - wff_full=1 -> stay in WR with no push, for as long as needed.
- RD_CMD:
  - wff_full=0 -> wr_en=1 with the read entry, then RD_WAIT with timer cleared.
  - wff_full=1 -> stay.
- RD_WAIT:
  - crf_empty=0 -> RD_POP.
  - Otherwise timer++; when timer == RD_TIMEOUT-1, go to ERR.
- RD_POP: crf_rd_en=1 for one cycle; prdata register <= crf_rd_data in the same cycle; then DONE.
- DONE: pready=1, pslverr=0; then IDLE.
- ERR: pready=1, pslverr=1, prdata=0; then IDLE. No push or pop occurs in this state.
- pready is 0 in every other state.
- prdata: holds the last captured value; it is only meaningful in DONE after a read.
- psel dropping in any state other than IDLE (protocol violation): return to IDLE next cycle with no further push or pop; a push already issued stands.
- Minimum latency, setup phase to pready:
  - Write: 3 cycles (setup, WR, DONE).
  - POP read with data already present: 4 cycles.
- At most one push and at most one pop per APB transfer, under all conditions.

Decomposition:
- Shared package fcb_apb_pkg holds:
  - the state enum typedef;
  - CMD_WR=1'b1 and CMD_RD=1'b0;
  - the entry field positions: [39] cmd, [38:32] addr, [31:0] data;
  - CFG_DATA_ADDR=7'h20.
- No sub-module. The timeout counter is inline.

Test Plan:
- Write at paddr=9'h080 with pwdata=32'hA5A5_0001, FIFO not full -> one wr_en pulse with data=40'hA0_A5A5_0001; pready on the 3rd cycle; pslverr=0.
- Write while wff_full=1 for 5 cycles, then full drops -> no push during the full cycles; exactly one push after; pready one cycle after the push.
- Read at paddr=9'h010; bench model returns crf data 32'h0000_005A 3 cycles after the push -> one push of 40'h04_0000_0000, one crf_rd_en, prdata=32'h5A, pslverr=0.
- Read at POP_ADDR (paddr=9'h1FC) with crf_empty held at 1 -> no push; ERR reached after RD_TIMEOUT cycles in wait; pslverr=1, prdata=0.
- fcb_apb_en=0 and a write is issued -> no push; pready=1 with pslverr=1 on the 2nd cycle; apb_on=0.
- Reset asserted during RD_WAIT -> next cycle state is IDLE, all outputs 0; a following write completes normally.
